// File: rtl/integral_image_builder.sv
// integral_image_builder: streaming summed-area table over one raster-order pyramid level.
// Define SQUARED_II_EN to add the parallel squared-pixel integral output ii_sq_data.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 320
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 240
`endif

module integral_image_builder #(
  parameter int unsigned WIDTH_LIMIT  = `LAPTOP_WIDTH,
  parameter int unsigned HEIGHT_LIMIT = `LAPTOP_HEIGHT,
  parameter int unsigned II_W         = 32
`ifdef SQUARED_II_EN
  ,
  parameter int unsigned SQ_W         = 40
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic [7:0]                      pix_data,
  output logic                            ii_valid,
  input  logic                            ii_ready,
  output logic [II_W-1:0]                 ii_data,
  output logic [$clog2(WIDTH_LIMIT)-1:0]  ii_x,
  output logic [$clog2(HEIGHT_LIMIT)-1:0] ii_y,
  output logic                            busy,
  output logic                            frame_done
`ifdef SQUARED_II_EN
  ,
  output logic [SQ_W-1:0]                 ii_sq_data
`endif
);

  localparam int unsigned XW = $clog2(WIDTH_LIMIT);
  localparam int unsigned YW = $clog2(HEIGHT_LIMIT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH_LIMIT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            all_acc_q, all_acc_d;
  logic [II_W-1:0] row_sum_q, row_sum_d;
  logic [II_W-1:0] line_buf_q [WIDTH_LIMIT];
  logic [II_W-1:0] line_buf_d [WIDTH_LIMIT];
  logic            ii_valid_q, ii_valid_d;
  logic [II_W-1:0] ii_data_q, ii_data_d;
  logic [XW-1:0]   ii_x_q, ii_x_d;
  logic [YW-1:0]   ii_y_q, ii_y_d;
  logic            pix_acc, ii_out_acc;
  logic [II_W-1:0] row_base, above, ii_sum;
`ifdef SQUARED_II_EN
  logic [SQ_W-1:0] sq_row_q, sq_row_d;
  logic [SQ_W-1:0] sq_buf_q [WIDTH_LIMIT];
  logic [SQ_W-1:0] sq_buf_d [WIDTH_LIMIT];
  logic [SQ_W-1:0] ii_sq_q, ii_sq_d;
  logic [SQ_W-1:0] sq_base, sq_above, sq_sum;
  logic [15:0]     pix_sq;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    all_acc_d  = all_acc_q;
    row_sum_d  = row_sum_q;
    line_buf_d = line_buf_q;
    ii_valid_d = ii_valid_q;
    ii_data_d  = ii_data_q;
    ii_x_d     = ii_x_q;
    ii_y_d     = ii_y_q;
    row_base   = '0;
    above      = '0;
    ii_sum     = '0;
`ifdef SQUARED_II_EN
    sq_row_d   = sq_row_q;
    sq_buf_d   = sq_buf_q;
    ii_sq_d    = ii_sq_q;
    sq_base    = '0;
    sq_above   = '0;
    sq_sum     = '0;
    pix_sq     = {8'd0, pix_data} * {8'd0, pix_data};
`endif

    // Output register frees up when consumed, so a new pixel may land in the same cycle.
    pix_ready  = (state_q == S_RUN) && (!ii_valid_q || ii_ready) && !all_acc_q;
    pix_acc    = pix_valid && pix_ready;
    ii_out_acc = ii_valid_q && ii_ready;
    if (ii_out_acc) ii_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          x_d        = '0;
          y_d        = '0;
          all_acc_d  = 1'b0;
          row_sum_d  = '0;
          line_buf_d = '{default: '0};
`ifdef SQUARED_II_EN
          sq_row_d   = '0;
          sq_buf_d   = '{default: '0};
`endif
        end
      end
      S_RUN: begin
        if (pix_acc) begin
          row_base   = (x_q == '0) ? '0 : row_sum_q;
          above      = (y_q == '0) ? '0 : line_buf_q[x_q];
          row_sum_d  = row_base + II_W'(pix_data);
          ii_sum     = row_sum_d + above;
          line_buf_d[x_q] = ii_sum;
          ii_valid_d = 1'b1;
          ii_data_d  = ii_sum;
          ii_x_d     = x_q;
          ii_y_d     = y_q;
`ifdef SQUARED_II_EN
          sq_base    = (x_q == '0) ? '0 : sq_row_q;
          sq_above   = (y_q == '0) ? '0 : sq_buf_q[x_q];
          sq_row_d   = sq_base + SQ_W'(pix_sq);
          sq_sum     = sq_row_d + sq_above;
          sq_buf_d[x_q] = sq_sum;
          ii_sq_d    = sq_sum;
`endif
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) all_acc_d = 1'b1;
            else               y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        if (all_acc_q && ii_out_acc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      all_acc_q  <= 1'b0;
      row_sum_q  <= '0;
      line_buf_q <= '{default: '0};
      ii_valid_q <= 1'b0;
      ii_data_q  <= '0;
      ii_x_q     <= '0;
      ii_y_q     <= '0;
`ifdef SQUARED_II_EN
      sq_row_q   <= '0;
      sq_buf_q   <= '{default: '0};
      ii_sq_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      all_acc_q  <= all_acc_d;
      row_sum_q  <= row_sum_d;
      line_buf_q <= line_buf_d;
      ii_valid_q <= ii_valid_d;
      ii_data_q  <= ii_data_d;
      ii_x_q     <= ii_x_d;
      ii_y_q     <= ii_y_d;
`ifdef SQUARED_II_EN
      sq_row_q   <= sq_row_d;
      sq_buf_q   <= sq_buf_d;
      ii_sq_q    <= ii_sq_d;
`endif
    end
  end

  assign ii_valid   = ii_valid_q;
  assign ii_data    = ii_data_q;
  assign ii_x       = ii_x_q;
  assign ii_y       = ii_y_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = (state_q == S_DONE);
`ifdef SQUARED_II_EN
  assign ii_sq_data = ii_sq_q;
`endif

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed, table-driven bench for integral_image_builder (4x3 main instance, 8x8 saturation-free instance).
module tb_integral_image_builder;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] exp_ii;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  x;
    logic [1:0]  y;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, pix_valid, pix_ready, ii_valid, ii_ready, busy, frame_done;
  logic [7:0]  pix_data;
  logic [31:0] ii_data;
  logic [1:0]  ii_x, ii_y;

  logic        start8, pix_valid8, pix_ready8, ii_valid8, ii_ready8, busy8, frame_done8;
  logic [7:0]  pix_data8;
  logic [31:0] ii_data8;
  logic [2:0]  ii_x8, ii_y8;

`ifdef SQUARED_II_EN
  logic [39:0] ii_sq_data, ii_sq_data8, last_sq;
`endif

  integral_image_builder #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .II_W(32)) dut (
    .clock(clk), .reset_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .ii_valid(ii_valid), .ii_ready(ii_ready), .ii_data(ii_data),
    .ii_x(ii_x), .ii_y(ii_y), .busy(busy), .frame_done(frame_done)
`ifdef SQUARED_II_EN
    , .ii_sq_data(ii_sq_data)
`endif
  );

  integral_image_builder #(.WIDTH_LIMIT(8), .HEIGHT_LIMIT(8), .II_W(32)) dut8 (
    .clock(clk), .reset_n(rst_n), .start(start8), .pix_valid(pix_valid8), .pix_ready(pix_ready8),
    .pix_data(pix_data8), .ii_valid(ii_valid8), .ii_ready(ii_ready8), .ii_data(ii_data8),
    .ii_x(ii_x8), .ii_y(ii_y8), .busy(busy8), .frame_done(frame_done8)
`ifdef SQUARED_II_EN
    , .ii_sq_data(ii_sq_data8)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the main instance; also owns ii_ready so stalls line up with the handshake.
  out_t        got[$];
  int          last_xfer_cyc = -1;
  int          fd_cyc = -1;
  int          fd_cnt = 0;
  bit          stall_en = 1'b0;
  bit          stalled = 1'b0;
  int          stall_left = 0;
  logic [31:0] hold;

  always @(negedge clk) begin
    if (stall_left > 0) begin
      check("stall ii_valid", ii_valid, 1);
      check("stall ii_data", ii_data, hold);
      check("stall pix_ready", pix_ready, 0);
      stall_left--;
      if (stall_left == 0) ii_ready = 1'b1;
    end else if (stall_en && !stalled && ii_valid && ii_x == 2'd1 && ii_y == 2'd1) begin
      stalled    = 1'b1;
      ii_ready   = 1'b0;
      hold       = ii_data;
      stall_left = 5;
    end
    if (ii_valid && ii_ready) begin
      got.push_back('{ii_data, ii_x, ii_y});
      last_xfer_cyc = cyc;
`ifdef SQUARED_II_EN
      last_sq = ii_sq_data;
`endif
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  logic [31:0] last8;
  logic [2:0]  last8_x, last8_y;
  int          n8 = 0;
  int          fd8 = 0;
  always @(negedge clk) begin
    if (ii_valid8 && ii_ready8) begin
      last8   = ii_data8;
      last8_x = ii_x8;
      last8_y = ii_y8;
      n8++;
    end
    if (frame_done8) fd8++;
  end

  vec_t vec_ones[N], vec_ramp[N], vec_twos[N], vec_threes[N], cur[N];

  task automatic run_frame(input string tag, input int start_at, input bit stall);
    int t, fd0, waits;
    got.delete();
    stalled  = 1'b0;
    stall_en = stall;
    fd0      = fd_cnt;
    waits    = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < N; i++) begin
      pix_valid = 1'b1;
      pix_data  = cur[i].pix;
      start     = (i == start_at);
      t = 0;
      @(negedge clk); #1;
      while (!pix_ready && t < 40) begin
        waits++;
        t++;
        @(negedge clk); #1;
      end
      if (!pix_ready) begin
        checks++;
        errors++;
        $display("FAIL %s pixel %0d: pix_ready never rose, got 0, expected 1", tag, i);
        break;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    t = 0;
    while (fd_cnt == fd0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check($sformatf("%s frame_done pulses", tag), fd_cnt - fd0, 1);
    check($sformatf("%s frame_done cycle", tag), fd_cyc, last_xfer_cyc + 1);
    check($sformatf("%s busy after", tag), busy, 0);
    if (!stall) check($sformatf("%s input stalls", tag), waits, 0);
    check($sformatf("%s output count", tag), got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++) begin
      check($sformatf("%s ii[%0d]", tag, i), got[i].data, cur[i].exp_ii);
      check($sformatf("%s x[%0d]", tag, i), got[i].x, i % W);
      check($sformatf("%s y[%0d]", tag, i), got[i].y, i / W);
    end
    stall_en = 1'b0;
  endtask

  initial begin
    automatic logic [31:0] ramp_exp[N] = '{1, 3, 6, 10, 6, 14, 24, 36, 15, 33, 54, 78};
    for (int i = 0; i < N; i++) begin
      vec_ones[i]   = '{8'd1, 32'((i % W + 1) * (i / W + 1))};
      vec_twos[i]   = '{8'd2, 32'(2 * (i % W + 1) * (i / W + 1))};
      vec_threes[i] = '{8'd3, 32'(3 * (i % W + 1) * (i / W + 1))};
      vec_ramp[i]   = '{8'(i + 1), ramp_exp[i]};
    end

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; ii_ready = 1'b1;
    start8 = 1'b0; pix_valid8 = 1'b0; pix_data8 = '0; ii_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset pix_ready", pix_ready, 0);
    check("reset ii_valid", ii_valid, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset ii_data", ii_data, 0);
    check("reset ii_x", ii_x, 0);
    check("reset ii_y", ii_y, 0);

    // Pixels offered while idle must be refused.
    @(posedge clk); #1 pix_valid = 1'b1; pix_data = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle pix_ready", pix_ready, 0);
      check("idle busy", busy, 0);
      check("idle ii_valid", ii_valid, 0);
    end
    @(posedge clk); #1 pix_valid = 1'b0;

    cur = vec_ones;
    run_frame("ones", -1, 1'b0);
    cur = vec_ramp;
    run_frame("ramp+start", 5, 1'b0);
    cur = vec_ramp;
    run_frame("ramp+stall", -1, 1'b1);
    check("stall happened", stalled, 1);

    // Reset in the middle of a frame, then a clean frame.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'd5;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset pix_ready", pix_ready, 0);
    check("midreset ii_valid", ii_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset ii_data", ii_data, 0);
    check("midreset ii_x", ii_x, 0);
    check("midreset ii_y", ii_y, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    cur = vec_twos;
    run_frame("twos", -1, 1'b0);

`ifdef SQUARED_II_EN
    cur = vec_threes;
    run_frame("threes", -1, 1'b0);
    check("threes ii_sq final", last_sq, 108);
`endif

    // 8x8 frame of 255: largest sum must not wrap.
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      automatic int t = 0;
      pix_valid8 = 1'b1;
      pix_data8  = 8'd255;
      @(negedge clk); #1;
      while (!pix_ready8 && t < 40) begin
        t++;
        @(negedge clk); #1;
      end
      if (!pix_ready8) begin
        checks++;
        errors++;
        $display("FAIL max8 pixel %0d: pix_ready never rose, got 0, expected 1", i);
        break;
      end
      @(posedge clk); #1;
    end
    pix_valid8 = 1'b0;
    begin
      automatic int t = 0;
      while (fd8 == 0 && t < 60) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (2) @(negedge clk);
    check("max8 frame_done", fd8, 1);
    check("max8 count", n8, 64);
    check("max8 final ii", last8, 16320);
    check("max8 final x", last8_x, 7);
    check("max8 final y", last8_y, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
